// File: rtl/branch_predict_unit_pkg.sv
// Shared opcode header plus branch-predictor types and helpers.
package branch_predict_unit_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CTR_W = 2;
  localparam int unsigned CNT_W = 16;

  // Decode-stage opcodes
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h1;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h2;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h3;
  localparam logic [OP_W-1:0] OP_CALL = 4'h4;
  localparam logic [OP_W-1:0] OP_RET  = 4'h5;
  localparam logic [OP_W-1:0] OP_FOR  = 4'h6;

  // 2-bit saturating counter encodings; MSB is the taken prediction
  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Branch class decoded from the opcode
  typedef struct packed {
    logic is_beq;
    logic is_bne;
    logic is_uncond;
  } br_dec_t;

  // Saturating step toward taken / not-taken
  function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    case (cur)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = CTR_WNT;
    endcase
    return nxt;
  endfunction

  // Classify a decode-stage opcode
  function automatic br_dec_t br_decode(input logic [OP_W-1:0] op);
    br_dec_t d;
    d.is_beq    = (op == OP_BEQ);
    d.is_bne    = (op == OP_BNE);
    d.is_uncond = (op == OP_JMP) | (op == OP_CALL) | (op == OP_RET) | (op == OP_FOR);
    return d;
  endfunction

endpackage

// File: rtl/branch_predict_unit_pht_table.sv
// Pattern history table: 2-bit counters, one read port with write bypass,
// one read-modify-write update port, asynchronous reset to weakly not-taken.
module pht_table
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t table_q [DEPTH];
  ctr_t wr_next_c;

  // Post-update value of the entry being trained
  always_comb begin
    wr_next_c = ctr_update(table_q[wr_idx], wr_taken);
  end

  // Read port returns the freshly trained value on an index collision
  always_comb begin
    rd_ctr_c = table_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_ctr_c = wr_next_c;
    end
  end

  // Counter storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i] <= CTR_WNT;
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= wr_next_c;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor / resolver: PHT-based fetch prediction, decode-stage
// BEQ/BNE resolution, fetch kill and not-taken redirect, mispredict counter.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PC_W       = 16,
  parameter int unsigned PHT_DEPTH  = 16,
  parameter int unsigned PREDICT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] bus_a_fwd,
  input  logic [DATA_W-1:0] bus_b_fwd,
  output logic              pred_taken,
  output logic              kill,
  output logic              zero,
  output logic              redirect_nt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int unsigned IDX_W = (PHT_DEPTH > 1) ? $clog2(PHT_DEPTH) : 1;

  br_dec_t dec_c;
  logic    equal_c;
  logic    cond_c;
  logic    taken_c;
  logic    act_c;
  logic    unused_pc;

  // Upper PC bits (and fetch inputs in static mode) do not index the table
  assign unused_pc = ^{if_valid, if_pc, id_pc};

  // Decode-stage resolution
  always_comb begin
    dec_c   = br_decode(id_op);
    equal_c = (bus_a_fwd == bus_b_fwd);
    cond_c  = dec_c.is_beq | dec_c.is_bne;
    taken_c = (dec_c.is_beq & equal_c) | (dec_c.is_bne & ~equal_c);
    act_c   = rst_n & id_valid & ~stall;
  end

  // Operand-equality flag, forced low in reset
  assign zero = rst_n & cond_c & equal_c;

  if (PREDICT_EN != 0) begin : g_pred
    ctr_t rd_ctr_c;
    logic pred_q;

    pht_table #(
      .DEPTH (PHT_DEPTH),
      .IDX_W (IDX_W)
    ) u_pht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (if_pc[IDX_W-1:0]),
      .rd_ctr_c (rd_ctr_c),
      .wr_en    (act_c & cond_c),
      .wr_idx   (id_pc[IDX_W-1:0]),
      .wr_taken (taken_c)
    );

    // Prediction travels with the fetched instruction into decode
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pred_q <= 1'b0;
      end else if (!stall) begin
        pred_q <= if_valid & rd_ctr_c[1];
      end
    end

    assign pred_taken = pred_q;
  end else begin : g_static
    assign pred_taken = 1'b0;
  end

  // Fetch kill and not-taken redirect
  always_comb begin
    kill        = 1'b0;
    redirect_nt = 1'b0;
    if (act_c) begin
      if (PREDICT_EN != 0) begin
        redirect_nt = cond_c & ~taken_c & pred_taken;
        kill        = dec_c.is_uncond | (cond_c & taken_c & ~pred_taken) | redirect_nt;
      end else begin
        kill = dec_c.is_uncond | (cond_c & taken_c);
      end
    end
  end

  // Saturating count of conditional-branch mispredicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (cond_c && (kill || redirect_nt) && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: predicting and static builds.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_pc;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [15:0] id_pc;
  logic [15:0] bus_a_fwd;
  logic [15:0] bus_b_fwd;

  logic        pred_taken, kill, zero, redirect_nt;
  logic [15:0] mispredict_cnt;
  logic        pred_taken_s, kill_s, zero_s, redirect_nt_s;
  logic [15:0] mispredict_cnt_s;

  int n_checks = 0;
  int n_err    = 0;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc),
    .id_valid(id_valid), .id_op(id_op), .id_pc(id_pc),
    .bus_a_fwd(bus_a_fwd), .bus_b_fwd(bus_b_fwd),
    .pred_taken(pred_taken), .kill(kill), .zero(zero),
    .redirect_nt(redirect_nt), .mispredict_cnt(mispredict_cnt)
  );

  branch_predict_unit #(.PREDICT_EN(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc),
    .id_valid(id_valid), .id_op(id_op), .id_pc(id_pc),
    .bus_a_fwd(bus_a_fwd), .bus_b_fwd(bus_b_fwd),
    .pred_taken(pred_taken_s), .kill(kill_s), .zero(zero_s),
    .redirect_nt(redirect_nt_s), .mispredict_cnt(mispredict_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [15:0] pc,
                        input logic [15:0] a, input logic [15:0] b);
    id_valid  = v;
    id_op     = op;
    id_pc     = pc;
    bus_a_fwd = a;
    bus_b_fwd = b;
  endtask

  task automatic set_if(input logic v, input logic [15:0] pc);
    if_valid = v;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    set_if(1'b0, 16'h0000);
    // Reset with a taken BEQ presented: outputs must be forced low
    set_id(1'b1, OP_BEQ, 16'h0004, 16'h1234, 16'h1234);
    #2;
    chk("rst_pred", 32'(pred_taken), 32'd0);
    chk("rst_cnt", 32'(mispredict_cnt), 32'd0);
    chk("rst_kill", 32'(kill), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_redir", 32'(redirect_nt), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b0, OP_NOP, 16'h0000, 16'h0000, 16'h0000);
    set_if(1'b1, 16'h0030);
    @(negedge clk);
    chk("fresh_pc_nt", 32'(pred_taken), 32'd0);

    // Fetch index 4 (entry WNT)
    set_if(1'b1, 16'h0004);
    @(negedge clk);
    chk("fetch4_pred0", 32'(pred_taken), 32'd0);
    // First BEQ at 0x0004, taken, predicted not-taken; second BEQ fetched
    set_id(1'b1, OP_BEQ, 16'h0004, 16'h1234, 16'h1234);
    #1;
    chk("beq1_kill", 32'(kill), 32'd1);
    chk("beq1_zero", 32'(zero), 32'd1);
    chk("beq1_redir", 32'(redirect_nt), 32'd0);
    @(negedge clk);
    chk("beq2_pred", 32'(pred_taken), 32'd1);
    chk("beq1_cnt", 32'(mispredict_cnt), 32'd1);
    set_if(1'b0, 16'h0000);
    #1;
    chk("beq2_kill", 32'(kill), 32'd0);
    chk("beq2_redir", 32'(redirect_nt), 32'd0);
    // Entry now ST; fetch it to get a taken prediction
    @(negedge clk);
    set_id(1'b0, OP_NOP, 16'h0000, 16'h0000, 16'h0000);
    set_if(1'b1, 16'h0004);
    @(negedge clk);
    chk("st_pred", 32'(pred_taken), 32'd1);
    // BNE with equal operands, predicted taken -> redirect, ST->WT
    set_id(1'b1, OP_BNE, 16'h0004, 16'h0001, 16'h0001);
    #1;
    chk("bne1_redir", 32'(redirect_nt), 32'd1);
    chk("bne1_kill", 32'(kill), 32'd1);
    chk("bne1_zero", 32'(zero), 32'd1);
    @(negedge clk);
    chk("bne1_cnt", 32'(mispredict_cnt), 32'd2);
    chk("wt_pred", 32'(pred_taken), 32'd1);
    #1;
    chk("bne2_redir", 32'(redirect_nt), 32'd1);
    // WT->WNT: prediction drops
    @(negedge clk);
    chk("wnt_pred", 32'(pred_taken), 32'd0);
    chk("bne2_cnt", 32'(mispredict_cnt), 32'd3);
    // BEQ not equal, predicted not-taken: correct, WNT->SNT
    set_id(1'b1, OP_BEQ, 16'h0004, 16'h0001, 16'h0002);
    #1;
    chk("beq_ne_kill", 32'(kill), 32'd0);
    chk("beq_ne_zero", 32'(zero), 32'd0);
    chk("beq_ne_redir", 32'(redirect_nt), 32'd0);
    // Same-cycle update and fetch: SNT->WNT reads 0
    @(negedge clk);
    set_id(1'b1, OP_BEQ, 16'h0004, 16'h00AA, 16'h00AA);
    #1;
    chk("byp_a_kill", 32'(kill), 32'd1);
    @(negedge clk);
    chk("byp_snt_wnt", 32'(pred_taken), 32'd0);
    chk("byp_a_cnt", 32'(mispredict_cnt), 32'd4);
    #1;
    chk("byp_b_kill", 32'(kill), 32'd1);
    // WNT->WT with bypass reads 1
    @(negedge clk);
    chk("byp_wnt_wt", 32'(pred_taken), 32'd1);
    chk("byp_b_cnt", 32'(mispredict_cnt), 32'd5);

    // Unconditional ops: kill, no table change, no count
    set_id(1'b1, OP_JMP, 16'h0004, 16'h0005, 16'h0005);
    #1;
    chk("jmp_kill", 32'(kill), 32'd1);
    chk("jmp_zero", 32'(zero), 32'd0);
    chk("jmp_redir", 32'(redirect_nt), 32'd0);
    @(negedge clk);
    id_op = OP_CALL;
    #1;
    chk("call_kill", 32'(kill), 32'd1);
    @(negedge clk);
    id_op = OP_RET;
    #1;
    chk("ret_kill", 32'(kill), 32'd1);
    @(negedge clk);
    id_op = OP_FOR;
    #1;
    chk("for_kill", 32'(kill), 32'd1);
    @(negedge clk);
    chk("uncond_pred", 32'(pred_taken), 32'd1);
    chk("uncond_cnt", 32'(mispredict_cnt), 32'd5);

    // Stall: BNE equal with taken prediction must not redirect or train
    stall = 1'b1;
    set_if(1'b0, 16'h0000);
    set_id(1'b1, OP_BNE, 16'h0004, 16'h0007, 16'h0007);
    #1;
    chk("stall_kill", 32'(kill), 32'd0);
    chk("stall_redir", 32'(redirect_nt), 32'd0);
    @(negedge clk);
    chk("stall_pred_hold", 32'(pred_taken), 32'd1);
    chk("stall_cnt_hold", 32'(mispredict_cnt), 32'd5);
    @(negedge clk);
    // id_valid low: no kill, zero still reflects operands
    stall = 1'b0;
    set_id(1'b0, OP_BEQ, 16'h0004, 16'h0009, 16'h0009);
    #1;
    chk("idv0_kill", 32'(kill), 32'd0);
    chk("idv0_zero", 32'(zero), 32'd1);
    set_if(1'b1, 16'h0004);
    @(negedge clk);
    chk("stall_no_train", 32'(pred_taken), 32'd1);

    // Reset mid-operation discards the in-flight update (WT->ST)
    set_id(1'b1, OP_BEQ, 16'h0004, 16'h0003, 16'h0003);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pred", 32'(pred_taken), 32'd0);
    chk("midrst_cnt", 32'(mispredict_cnt), 32'd0);
    chk("midrst_kill", 32'(kill), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b0, OP_NOP, 16'h0000, 16'h0000, 16'h0000);
    set_if(1'b1, 16'h0004);
    @(negedge clk);
    chk("post_rst_wnt", 32'(pred_taken), 32'd0);

    // Static not-taken build
    set_if(1'b0, 16'h0000);
    set_id(1'b1, OP_BEQ, 16'h0008, 16'h4321, 16'h4321);
    #1;
    chk("s_beq_eq_kill", 32'(kill_s), 32'd1);
    chk("s_beq_eq_zero", 32'(zero_s), 32'd1);
    chk("s_pred", 32'(pred_taken_s), 32'd0);
    id_op = OP_BNE;
    #1;
    chk("s_bne_eq_kill", 32'(kill_s), 32'd0);
    chk("s_bne_eq_redir", 32'(redirect_nt_s), 32'd0);
    bus_b_fwd = 16'h4320;
    #1;
    chk("s_bne_ne_kill", 32'(kill_s), 32'd1);
    id_op = OP_JMP;
    #1;
    chk("s_jmp_kill", 32'(kill_s), 32'd1);
    @(negedge clk);
    chk("s_cnt_start", 32'(mispredict_cnt_s), 32'd0);

    // 65536 forced mispredicts saturate both counters
    set_id(1'b1, OP_BEQ, 16'h0008, 16'h0011, 16'h0011);
    repeat (65536) @(posedge clk);
    @(negedge clk);
    chk("s_cnt_sat", 32'(mispredict_cnt_s), 32'h0000FFFF);
    chk("p_cnt_sat", 32'(mispredict_cnt), 32'h0000FFFF);
    repeat (3) @(negedge clk);
    chk("s_cnt_sat_hold", 32'(mispredict_cnt_s), 32'h0000FFFF);
    chk("p_cnt_sat_hold", 32'(mispredict_cnt), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width compared for BEQ/BNE.
REQ-002 SHALL have parameter PC_W, default 16, program-counter width.
REQ-003 SHALL have parameter PHT_DEPTH, default 16, pattern-history-table entries (power of 2, 2..256).
REQ-004 SHALL have parameter PREDICT_EN, default 1; 0 = static not-taken mode.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 stall  in  1  hold all state; suppress table update and kill.
REQ-008 if_valid  in  1  fetch-stage instruction valid.
REQ-009 if_pc  in  PC_W  fetch-stage PC.
REQ-010 id_valid  in  1  decode-stage instruction valid.
REQ-011 id_op  in  4  decode-stage opcode (shared opcode header).
REQ-012 id_pc  in  PC_W  decode-stage PC.
REQ-013 bus_a_fwd, bus_b_fwd  in  DATA_W each  forwarded operands.
REQ-014 pred_taken  out  1  registered prediction travelling with the if→id instruction.
REQ-015 kill  out  1  flush the fetch-stage instruction this cycle.
REQ-016 zero  out  1  BEQ/BNE operands equal.
REQ-017 redirect_nt  out  1  predicted-taken branch resolved not-taken; fetch returns to id_pc+1.
REQ-018 mispredict_cnt  out  16  saturating mispredict count.

Function
REQ-019 PHT index SHALL be pc[log2(PHT_DEPTH)-1:0]; each entry a 2-bit saturating counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-020 When if_valid & ~stall, pred_taken SHALL register MSB of PHT[if_pc index] one cycle later; when ~if_valid & ~stall it SHALL register 0; when stall it SHALL hold.
REQ-021 If the update in REQ-024 targets the same index as the fetch read in that cycle, the read SHALL return the post-update value (bypass).
REQ-022 zero SHALL be combinational: (id_op is BEQ or BNE) & (bus_a_fwd == bus_b_fwd), full DATA_W compare.
REQ-023 actual_taken SHALL be (BEQ & equal) | (BNE & ~equal); conditional = BEQ|BNE.
REQ-024 On id_valid & conditional & ~stall, PHT[id_pc index] SHALL increment if actual_taken, else decrement, saturating at 11 and 00.
REQ-025 kill SHALL be combinational and asserted when id_valid & ~stall & (JMP|CALL|RET|FOR, or conditional & actual_taken & ~pred_taken).
REQ-026 redirect_nt SHALL be asserted when id_valid & ~stall & conditional & ~actual_taken & pred_taken; kill SHALL also assert in this case.
REQ-027 Conditional & actual_taken & pred_taken SHALL assert neither kill nor redirect_nt.
REQ-028 mispredict_cnt SHALL increment by 1 each cycle kill or redirect_nt is asserted for a conditional branch, saturating at 16'hFFFF.
REQ-029 With PREDICT_EN=0, pred_taken SHALL be constant 0, the PHT SHALL be absent, and kill SHALL equal BEQ-taken | BNE-taken | JMP | CALL | RET | FOR.
REQ-030 With id_valid=0, kill, redirect_nt and zero-driven updates SHALL be 0; zero still reflects operands.

Reset
REQ-031 On rst_n low, every PHT entry SHALL become 01 (WNT) immediately, without a clock.
REQ-032 On rst_n low, pred_taken SHALL be 0 and mispredict_cnt 0; kill, redirect_nt and zero follow inputs and SHALL be forced to 0.
REQ-033 Reset mid-operation SHALL discard any in-flight update; first post-reset edge uses reset state.

Structure
REQ-034 Opcode constants SHALL remain in the shared opcode header; 2-bit counter encodings SHALL be added there.
REQ-035 The PHT SHALL be sub-module pht_table (PHT_DEPTH entries, one read port, one write port, read-bypass, async reset).

Verification
REQ-036 Reset → pred_taken=0, mispredict_cnt=0, any fresh PC predicts not-taken.
REQ-037 BEQ at id_pc=0x0004, a=b=0x1234, pred 0 → kill=1, zero=1, cnt=1; second BEQ same PC → pred_taken=1 (10), no kill.
REQ-038 BNE at 0x0004 with PHT=11, a=0x0001, b=0x0001 → redirect_nt=1, kill=1, entry→10.
REQ-039 Same-cycle update and fetch of index 4 (00→01 with update) → pred_taken next cycle reflects 01 (0); 01→10 case → 1.
REQ-040 JMP/CALL/RET/FOR each → kill=1, no PHT change; with stall=1 → kill=0, state held.
REQ-041 PREDICT_EN=0 build: BEQ equal → kill=1, BNE equal → kill=0; 65536 forced mispredicts → cnt stays 16'hFFFF.
